// File: rtl/reset_pulse_gen.sv
// rtl/reset_pulse_gen.sv - programmable synchronous reset pulse generator
// Drives an active-low reset of length max(req_len, MIN_CYCLES), then waits for downstream release.
module reset_pulse_gen #(
  parameter int CNT_WIDTH      = 8,
  parameter int MIN_CYCLES     = 2,
  parameter int TO_WIDTH       = 10,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req,
  input  logic [CNT_WIDTH-1:0] req_len,
  output logic                 out_rst,
  input  logic                 done_in,
  output logic                 busy,
  output logic                 ack,
  output logic                 timeout
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ASSERT = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_ACK    = 2'd3;

  localparam logic [CNT_WIDTH-1:0] MIN_LEN = CNT_WIDTH'(MIN_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [TO_WIDTH-1:0]  TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [1:0]           state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt, eff_len;
  logic [TO_WIDTH-1:0]  timer, timer_nxt;
  logic                 seen_low, seen_low_nxt;
  logic                 timeout_nxt;
  logic                 sync1, done_s;

  assign eff_len = (req_len >= MIN_LEN) ? req_len : MIN_LEN;

  // Synchronizer resets high so a quiet DONE_IN line never looks like a fresh low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      done_s <= 1'b1;
    end else begin
      sync1  <= done_in;
      done_s <= sync1;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    timer_nxt    = timer;
    seen_low_nxt = seen_low;
    timeout_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          state_nxt    = S_ASSERT;
          cnt_nxt      = eff_len;
          seen_low_nxt = 1'b0;
        end
      end
      S_ASSERT: begin
        cnt_nxt = cnt - CNT_ONE;
        if (!done_s) seen_low_nxt = 1'b1;
        if (cnt == CNT_ONE) begin
          state_nxt = S_WAIT;
          timer_nxt = '0;
        end
      end
      S_WAIT: begin
        if (!done_s) seen_low_nxt = 1'b1;
        // A completed handshake takes priority over a coincident timer expiry.
        if (seen_low && done_s) begin
          state_nxt = S_ACK;
        end else if (timer == TO_LAST) begin
          state_nxt   = S_ACK;
          timeout_nxt = 1'b1;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_ASSERT;
      cnt      <= MIN_LEN;
      timer    <= '0;
      seen_low <= 1'b0;
      out_rst  <= 1'b0;
      busy     <= 1'b1;
      ack      <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      timer    <= timer_nxt;
      seen_low <= seen_low_nxt;
      out_rst  <= (state_nxt != S_ASSERT);
      busy     <= (state_nxt != S_IDLE);
      ack      <= (state_nxt == S_ACK);
      timeout  <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_reset_pulse_gen.sv
// tb/tb_reset_pulse_gen.sv - self-checking bench for reset_pulse_gen
module tb_reset_pulse_gen;

  localparam int MIN = 2;
  localparam int TO  = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req;
  logic [7:0] req_len;
  logic       out_rst;
  logic       done_in;
  logic       busy;
  logic       ack;
  logic       timeout;

  reset_pulse_gen #(
    .CNT_WIDTH(8), .MIN_CYCLES(MIN), .TO_WIDTH(10), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_len(req_len), .out_rst(out_rst),
    .done_in(done_in), .busy(busy), .ack(ack), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a sequence is described by its start cycle, length and the cycle its ACK lands on.
  int  cyc = 0;
  int  m_t0, m_n, m_ack;
  bit  m_active, m_seen, m_to;
  bit  dq[$];
  int  dmode = 0;

  function automatic int m_phase();
    if (!m_active)               return 0;
    if (m_ack == cyc)            return 3;
    if (cyc - m_t0 < m_n)        return 1;
    return 2;
  endfunction

  function automatic logic [3:0] m_outs();
    case (m_phase())
      0:       return 4'b1000;
      1:       return 4'b0100;
      2:       return 4'b1100;
      default: return {3'b111, m_to};
    endcase
  endfunction

  task automatic m_advance();
    bit ds;
    int ph;
    ds = dq[0];
    ph = m_phase();
    if (ph == 0) begin
      if (req) begin
        m_active = 1;
        m_t0     = cyc + 1;
        m_n      = (int'(req_len) < MIN) ? MIN : int'(req_len);
        m_ack    = -1;
        m_seen   = 0;
      end
    end else if (ph == 3) begin
      m_active = 0;
    end else begin
      if (ph == 2) begin
        if (m_seen && ds) begin
          m_ack = cyc + 1; m_to = 0;
        end else if (cyc - m_t0 - m_n == TO - 1) begin
          m_ack = cyc + 1; m_to = 1;
        end
      end
      if (!ds) m_seen = 1;
    end
    dq.push_back(done_in);
    dq.delete(0);
  endtask

  int low_run, last_low, wait_run, last_wait, idle_run, ack_count;
  int n_gaps, min_gap, max_gap, rise_cyc, ack_lat;
  bit last_ack_to, prev_done;

  task automatic sample();
    check_eq("outs", {28'd0, out_rst, busy, ack, timeout}, {28'd0, m_outs()});
    if (!out_rst) low_run++;
    else if (low_run > 0) begin last_low = low_run; low_run = 0; end
    if (busy && out_rst && !ack) wait_run++;
    if (ack) begin
      last_wait = wait_run; wait_run = 0; last_ack_to = timeout;
      ack_count++; ack_lat = cyc - rise_cyc;
    end
    if (!busy) idle_run++;
    else if (idle_run > 0) begin
      n_gaps++;
      if (idle_run < min_gap) min_gap = idle_run;
      if (idle_run > max_gap) max_gap = idle_run;
      idle_run = 0;
    end
  endtask

  task automatic step();
    case (dmode)
      0:       done_in = out_rst;
      1:       done_in = 1'b1;
      2:       done_in = 1'($urandom_range(0, 1));
      default: done_in = (m_phase() == 2) && (cyc - m_t0 - m_n >= TO - 3);
    endcase
    if (done_in && !prev_done) rise_cyc = cyc;
    prev_done = done_in;
    m_advance();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    #1;
    sample();
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    #1;
    check_eq("rst_async", {28'd0, out_rst, busy, ack, timeout}, 32'b0100);
    repeat (2) @(posedge clk);
    cyc += 2;
    @(negedge clk);
    check_eq("rst_hold", {28'd0, out_rst, busy, ack, timeout}, 32'b0100);
    rst_n    = 1'b1;
    m_active = 1; m_t0 = cyc; m_n = MIN; m_ack = -1; m_seen = 0; m_to = 0;
    dq.delete();
    dq.push_back(1'b1);
    dq.push_back(1'b1);
    low_run = 0; wait_run = 0; idle_run = 0;
    #1;
    sample();
  endtask

  task automatic run_until_idle(input int budget);
    int k;
    k = 0;
    while (m_phase() != 0 && k < budget) begin step(); k++; end
    check_eq("idle_bound", {31'd0, busy}, 32'd0);
  endtask

  task automatic req_pulse(input int len);
    req = 1'b1; req_len = 8'(len);
    step();
    req = 1'b0; req_len = 8'($urandom);
    run_until_idle(100);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int acks_before;
    rst_n = 1'b1; req = 1'b0; req_len = '0; done_in = 1'b0; prev_done = 1'b0;
    last_low = 0; last_wait = 0; ack_count = 0; rise_cyc = 0; ack_lat = 0;
    n_gaps = 0; min_gap = 999; max_gap = 0;
    #2;

    dmode = 0;
    reset_dut();
    run_until_idle(100);
    check_eq("por_low_len", last_low, MIN);
    check_eq("por_acks", ack_count, 1);
    check_eq("por_timeout", {31'd0, last_ack_to}, 0);
    repeat (3) step();

    // Second request during ASSERT must be ignored.
    req = 1'b1; req_len = 8'd5; step();
    req = 1'b0; step();
    req = 1'b1; req_len = 8'd9; step();
    req = 1'b0;
    run_until_idle(100);
    check_eq("len5_low", last_low, 5);
    check_eq("len5_ack_lat_le4", {31'd0, ack_lat <= 4}, 1);
    repeat (2) step();

    req_pulse(0);  check_eq("len0_low", last_low, MIN);
    req_pulse(1);  check_eq("len1_low", last_low, MIN);
    req_pulse(9);  check_eq("len9_low", last_low, 9);

    dmode = 1;
    req_pulse(3);
    check_eq("to_wait_len", last_wait, TO);
    check_eq("to_flag", {31'd0, last_ack_to}, 1);

    dmode = 3;
    repeat (3) step();
    req_pulse(3);
    check_eq("coinc_wait_len", last_wait, TO);
    check_eq("coinc_flag", {31'd0, last_ack_to}, 0);

    dmode = 0;
    step();
    n_gaps = 0; min_gap = 999; max_gap = 0; idle_run = 0;
    req = 1'b1; req_len = 8'd3;
    repeat (40) step();
    req = 1'b0;
    run_until_idle(100);
    check_eq("held_seqs_ge3", {31'd0, n_gaps >= 3}, 1);
    check_eq("held_min_gap", min_gap, 1);
    check_eq("held_max_gap", max_gap, 1);

    // Abort during WAIT_REL: only the following power-on sequence may acknowledge.
    dmode = 1;
    req = 1'b1; req_len = 8'd4; step(); req = 1'b0;
    for (int k = 0; k < 60 && !(m_phase() == 2 && cyc - m_t0 - m_n == 5); k++) step();
    check_eq("reach_wait", {31'd0, busy && out_rst && !ack}, 1);
    acks_before = ack_count;
    dmode = 0;
    reset_dut();
    run_until_idle(100);
    check_eq("abort_acks", ack_count - acks_before, 1);
    check_eq("abort_por_low", last_low, MIN);

    for (int i = 0; i < 900; i++) begin
      if (m_phase() == 0) dmode = int'($urandom_range(0, 2));
      req     = ($urandom_range(0, 2) == 0);
      req_len = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 399) == 0) reset_dut();
      else step();
    end
    req = 1'b0;
    dmode = 0;
    run_until_idle(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
